// File: rtl/ptu_pkg.sv
// Shared mode codes, TX FSM state encoding and helpers for nibble_uart_tx.
// Parity support is compiled in only when PTU_PARITY_EN is defined.
package ptu_pkg;

  localparam logic [1:0] MODE_IDLE     = 2'b00;
  localparam logic [1:0] MODE_LOAD_LSB = 2'b01;
  localparam logic [1:0] MODE_LOAD_MSB = 2'b10;
  localparam logic [1:0] MODE_SEND     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  // All FSM registers grouped so checkers can bind to one signal.
  typedef struct packed {
    tx_state_t  state;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
  } tx_fsm_t;

  function automatic logic byte_parity(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/ptu_fifo.sv
// Synchronous byte FIFO with registered empty/full flags and occupancy count.
import ptu_pkg::*;

module ptu_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  // push/pop are single-cycle requests. A pop is accepted only when the FIFO
  // is non-empty (judged before any same-cycle push). A push is accepted when
  // not full, or when full and a pop is accepted in the same cycle.
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;
  logic [CW-1:0] count_next;

  assign pop_ok     = pop && !empty;
  assign push_ok    = push && (!full || pop_ok);
  assign count_next = count + CW'(push_ok) - CW'(pop_ok);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(DEPTH));
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nibble_uart_tx.sv
// Nibble-loaded byte FIFO feeding an 8N1/8N2 UART transmitter.
// Define PTU_PARITY_EN to insert a parity bit after data bit 7.
import ptu_pkg::*;

module nibble_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_pins,
  input  logic [1:0] mode,
  output logic       uart_tx,
  output logic       busy,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [1:0]    mode_q;
  logic [3:0]    lsb_q;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  tx_fsm_t       fsm;
  logic [BW-1:0] baud_cnt;
  logic [7:0]    shreg;
  logic          tx_q;
  logic          busy_q;
  logic          overflow_q;

  logic bit_done;
  logic stop_last;
  logic can_send;
  logic start_idle;
  logic start_b2b;

  // Nibble capture and entry detect on LOAD_MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_IDLE;
      lsb_q  <= 4'h0;
    end else begin
      mode_q <= mode;
      if (mode == MODE_LOAD_LSB) lsb_q <= data_pins;
    end
  end

  assign push = (mode == MODE_LOAD_MSB) && (mode_q != MODE_LOAD_MSB);

  ptu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({data_pins, lsb_q}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) overflow_q <= 1'b0;
    else if (push && fifo_full && !pop) overflow_q <= 1'b1;
  end

  assign bit_done   = (baud_cnt == BAUD_LAST);
  assign stop_last  = (STOP_BITS == 1) || fsm.stop_cnt;
  assign can_send   = (mode == MODE_SEND) && !fifo_empty;
  assign start_idle = (fsm.state == S_IDLE) && can_send;
  assign start_b2b  = (fsm.state == S_STOP) && bit_done && stop_last && can_send;
  assign pop        = start_idle || start_b2b;

`ifdef PTU_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset)    parity_q <= 1'b0;
    else if (pop) parity_q <= byte_parity(fifo_head, PARITY_ODD != 0);
  end
`endif

  // Baud counter restarts on every bit boundary so frames never drift.
  always_ff @(posedge clk) begin
    if (reset || fsm.state == S_IDLE || bit_done) baud_cnt <= '0;
    else                                          baud_cnt <= baud_cnt + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm    <= '{state: S_IDLE, bit_cnt: 3'd0, stop_cnt: 1'b0};
      shreg  <= 8'h00;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      case (fsm.state)
        S_IDLE: begin
          if (start_idle) begin
            fsm.state <= S_START;
            shreg     <= fifo_head;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_START: begin
          if (bit_done) begin
            fsm.state   <= S_DATA;
            fsm.bit_cnt <= 3'd0;
            tx_q        <= shreg[0];
          end
        end
        S_DATA: begin
          if (bit_done) begin
            if (fsm.bit_cnt == 3'd7) begin
`ifdef PTU_PARITY_EN
              fsm.state <= S_PARITY;
              tx_q      <= parity_q;
`else
              fsm.state    <= S_STOP;
              fsm.stop_cnt <= 1'b0;
              tx_q         <= 1'b1;
`endif
            end else begin
              fsm.bit_cnt <= fsm.bit_cnt + 3'd1;
              shreg       <= {1'b0, shreg[7:1]};
              tx_q        <= shreg[1];
            end
          end
        end
`ifdef PTU_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            fsm.state    <= S_STOP;
            fsm.stop_cnt <= 1'b0;
            tx_q         <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            if (!stop_last) begin
              fsm.stop_cnt <= 1'b1;
            end else if (start_b2b) begin
              fsm.state <= S_START;
              shreg     <= fifo_head;
              tx_q      <= 1'b0;
            end else begin
              fsm.state <= S_IDLE;
              busy_q    <= 1'b0;
            end
          end
        end
        default: begin
          fsm.state <= S_IDLE;
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (fifo_full == (fifo_count == CW'(FIFO_DEPTH)));
      assert (PARITY_ODD == 0 || PARITY_ODD == 1);
    end
  end

endmodule

// File: tb/tb_nibble_uart_tx.sv
// Directed bench for nibble_uart_tx at 4 clocks per bit, depth-4 FIFO, 1 stop bit.
import ptu_pkg::*;

module tb_nibble_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int STOPB = 1;
  localparam int PODD  = 0;
`ifdef PTU_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FBITS  = 1 + 8 + PBITS + STOPB;
  localparam int FCYC   = FBITS * CPB;

  logic       clk;
  logic       reset;
  logic [3:0] data_pins;
  logic [1:0] mode;
  logic       uart_tx;
  logic       busy;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  nibble_uart_tx #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOPB), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .reset(reset), .data_pins(data_pins), .mode(mode),
    .uart_tx(uart_tx), .busy(busy), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic load_byte(input logic [7:0] b);
    mode = MODE_LOAD_LSB; data_pins = b[3:0]; cycle();
    mode = MODE_LOAD_MSB; data_pins = b[7:4]; cycle();
    mode = MODE_IDLE;     data_pins = 4'h0;   cycle();
  endtask

  // Expected serial frame, bit 0 first; unused upper bits stay 1.
  function automatic logic [11:0] build_frame(input logic [7:0] b);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef PTU_PARITY_EN
    f[9] = (^b) ^ (PODD != 0);
`endif
    return f;
  endfunction

  // Samples one frame; optionally switches mode at cycle chg_at of the frame.
  task automatic capture_frame(input int chg_at, input logic [1:0] chg_mode,
                               output logic [11:0] bits, output bit stable,
                               output int nbusy);
    logic v;
    bits = '1; stable = 1'b1; nbusy = 0;
    for (int i = 0; i < FBITS; i++) begin
      for (int j = 0; j < CPB; j++) begin
        if (i * CPB + j == chg_at) mode = chg_mode;
        v = uart_tx;
        if (j == 0) bits[i] = v;
        else if (v !== bits[i]) stable = 1'b0;
        if (busy === 1'b1) nbusy++;
        cycle();
      end
    end
  endtask

  task automatic test_reset();
    int highs;
    reset = 1'b1; mode = MODE_SEND; data_pins = 4'h0;
    cycle(); cycle();
    n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    n_vec++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    reset = 1'b0;
    highs = 0;
    for (int k = 0; k < 50; k++) begin
      if (uart_tx === 1'b1 && busy === 1'b0) highs++;
      cycle();
    end
    n_vec++; if (highs !== 50) begin n_err++; $display("FAIL reset_idle_line: got %0d idle cycles expected 50", highs); end
    mode = MODE_IDLE;
    cycle();
  endtask

  task automatic test_single_frame();
    logic [11:0] bits; bit stable; int nbusy;
    load_byte(8'hA5); exp_q.push_back(8'hA5);
    n_vec++; if (fifo_empty !== 1'b0) begin n_err++; $display("FAIL single_loaded: got empty=%b expected 0", fifo_empty); end
    mode = MODE_SEND; cycle(); mode = MODE_IDLE;
    capture_frame(-1, MODE_IDLE, bits, stable, nbusy);
    // 0xA5 LSB first: start 0, data 1,0,1,0,0,1,0,1, stop 1
    n_vec++; if (bits !== build_frame(exp_q.pop_front())) begin n_err++; $display("FAIL single_bits: got %h expected %h", bits, build_frame(8'hA5)); end
    n_vec++; if (bits[8:0] !== 9'h14A) begin n_err++; $display("FAIL single_bits_hand: got %h expected 14a", bits[8:0]); end
    n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL single_bit_width: got unstable expected %0d-cycle bits", CPB); end
    n_vec++; if (nbusy !== FCYC) begin n_err++; $display("FAIL single_busy_len: got %0d expected %0d", nbusy, FCYC); end
    n_vec++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin n_err++; $display("FAIL single_after: got busy=%b tx=%b expected busy=0 tx=1", busy, uart_tx); end
    n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b expected 1", fifo_empty); end
  endtask

`ifdef PTU_PARITY_EN
  task automatic test_parity();
    logic [11:0] bits; bit stable; int nbusy;
    load_byte(8'hA5);
    mode = MODE_SEND; cycle(); mode = MODE_IDLE;
    capture_frame(-1, MODE_IDLE, bits, stable, nbusy);
    n_vec++; if (bits[9] !== 1'b0) begin n_err++; $display("FAIL parity_a5: got %b expected 0", bits[9]); end
    n_vec++; if (nbusy !== 44) begin n_err++; $display("FAIL parity_a5_len: got %0d expected 44", nbusy); end
    load_byte(8'h07);
    mode = MODE_SEND; cycle(); mode = MODE_IDLE;
    capture_frame(-1, MODE_IDLE, bits, stable, nbusy);
    n_vec++; if (bits[9] !== 1'b1) begin n_err++; $display("FAIL parity_07: got %b expected 1", bits[9]); end
    n_vec++; if (bits[8:1] !== 8'h07) begin n_err++; $display("FAIL parity_07_data: got %h expected 07", bits[8:1]); end
    n_vec++; if (nbusy !== 44) begin n_err++; $display("FAIL parity_07_len: got %0d expected 44", nbusy); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [11:0] bits; bit stable; int nbusy; logic [7:0] e;
    load_byte(8'h11); exp_q.push_back(8'h11);
    load_byte(8'h22); exp_q.push_back(8'h22);
    load_byte(8'h33); exp_q.push_back(8'h33);
    mode = MODE_SEND; cycle();
    for (int f = 0; f < 3; f++) begin
      capture_frame(-1, MODE_IDLE, bits, stable, nbusy);
      e = exp_q.pop_front();
      n_vec++; if (bits !== build_frame(e)) begin n_err++; $display("FAIL b2b_frame%0d: got %h expected %h", f, bits, build_frame(e)); end
      n_vec++; if (nbusy !== FCYC || stable !== 1'b1) begin n_err++; $display("FAIL b2b_len%0d: got busy=%0d stable=%b expected %0d 1", f, nbusy, stable, FCYC); end
      if (f == 0) begin
        n_vec++; if (fifo_empty !== 1'b0) begin n_err++; $display("FAIL b2b_empty_mid: got %b expected 0", fifo_empty); end
      end else if (f == 1) begin
        n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty_last: got %b expected 1", fifo_empty); end
      end
    end
    n_vec++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin n_err++; $display("FAIL b2b_done: got busy=%b tx=%b expected 0 1", busy, uart_tx); end
    mode = MODE_IDLE; cycle();
  endtask

  task automatic test_overflow();
    logic [11:0] bits; bit stable; int nbusy; logic [7:0] e;
    for (int k = 1; k <= 4; k++) begin
      load_byte(8'(k * 8'h11)); exp_q.push_back(8'(k * 8'h11));
    end
    n_vec++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_depth: got full=%b ovf=%b expected 1 0", fifo_full, overflow); end
    load_byte(8'h55);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_vec++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
    mode = MODE_SEND; cycle();
    for (int f = 0; f < 4; f++) begin
      capture_frame(-1, MODE_IDLE, bits, stable, nbusy);
      e = exp_q.pop_front();
      n_vec++; if (bits !== build_frame(e)) begin n_err++; $display("FAIL ovf_frame%0d: got %h expected %h", f, bits, build_frame(e)); end
    end
    n_vec++; if (busy !== 1'b0 || fifo_empty !== 1'b1) begin n_err++; $display("FAIL ovf_drain: got busy=%b empty=%b expected 0 1", busy, fifo_empty); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    mode = MODE_IDLE; cycle();
  endtask

  task automatic test_mode_change_mid();
    logic [11:0] bits; bit stable; int nbusy; int quiet;
    load_byte(8'h3C); load_byte(8'h5A);
    mode = MODE_SEND; cycle();
    capture_frame(4 * CPB + 1, MODE_IDLE, bits, stable, nbusy);
    n_vec++; if (bits !== build_frame(8'h3C)) begin n_err++; $display("FAIL midmode_frame: got %h expected %h", bits, build_frame(8'h3C)); end
    n_vec++; if (nbusy !== FCYC) begin n_err++; $display("FAIL midmode_len: got %0d expected %0d", nbusy, FCYC); end
    quiet = 0;
    for (int k = 0; k < 20; k++) begin
      if (uart_tx === 1'b1 && busy === 1'b0) quiet++;
      cycle();
    end
    n_vec++; if (quiet !== 20) begin n_err++; $display("FAIL midmode_no_restart: got %0d idle cycles expected 20", quiet); end
    n_vec++; if (fifo_empty !== 1'b0) begin n_err++; $display("FAIL midmode_kept: got empty=%b expected 0", fifo_empty); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; cycle(); reset = 1'b0; cycle();
    load_byte(8'h96); load_byte(8'h0F);
    mode = MODE_SEND; cycle(); mode = MODE_IDLE;
    for (int k = 0; k < 4 * CPB + 1; k++) cycle();
    // inside data bit 3 of 0x96, which is 0
    n_vec++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL rstmid_bit3: got %b expected 0", uart_tx); end
    reset = 1'b1; cycle();
    n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL rstmid_tx: got %b expected 1", uart_tx); end
    n_vec++; if (fifo_empty !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_state: got empty=%b busy=%b expected 1 0", fifo_empty, busy); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf_clear: got %b expected 0", overflow); end
    reset = 1'b0; cycle();
  endtask

  initial begin
    reset = 1'b1; mode = MODE_IDLE; data_pins = 4'h0;
    test_reset();
    test_single_frame();
`ifdef PTU_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_overflow();
    test_mode_change_mid();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_uart_tx.md
# nibble_uart_tx

Parametrised successor to the single-byte parallel-to-UART loader: accepts bytes as two 4-bit nibbles over a mode-selected parallel bus, queues them in a small FIFO, and serialises them as 8N1/8N2 UART frames, optionally with parity, at a configurable clocks-per-bit rate. It sits behind the chip-level pin wrapper, which maps the 8-bit input pins onto `clk`, `reset`, `data_pins` and `mode`, and drives `uart_tx` and the status flags onto the output pins.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, at least 2.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Used only when `PTU_PARITY_EN` is defined.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_pins`  in  4  nibble input.
- `mode`  in  2  00 IDLE, 01 LOAD_LSB, 10 LOAD_MSB, 11 SEND.
- `uart_tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in flight.
- `fifo_empty`  out  1  FIFO holds 0 bytes.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `overflow`  out  1  sticky; set when a push is dropped.

## Operation
- **Reset values:** `uart_tx`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0. The nibble register clears to 0, the FIFO empties, and the FSM goes to S_IDLE.
- **LOAD_LSB:** `lsb_q <= data_pins` on every cycle that `mode`==01.
- **LOAD_MSB:** the push happens only on entry, i.e. when `mode`==10 and `mode_q`!=10 (`mode_q` is the registered previous mode).
  - The pushed byte is {`data_pins`, `lsb_q`}, using the *current* `data_pins`.
  - Holding `mode`=10 pushes exactly once.
- **Push when full:** the byte is dropped, `overflow` sets to 1 and stays set until reset.
- **SEND:** the FSM starts a frame when in S_IDLE with `mode`==11 and `fifo_empty`==0, popping the FIFO head in that cycle.
- **Frame in flight:** once started, a frame always completes, whatever `mode` does afterwards.
- **FSM:**
  - S_IDLE → S_START on start condition.
  - S_START → S_DATA after `CLKS_PER_BIT` cycles.
  - S_DATA sends 8 bits, LSB first, each for `CLKS_PER_BIT` cycles, then → S_PARITY (macro defined) or S_STOP.
  - S_PARITY → S_STOP after 1 bit time.
  - S_STOP holds `uart_tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles, then → S_IDLE.
- **Back-to-back frames:** in the final cycle of S_STOP, if `mode`==11 and the FIFO is non-empty, pop and go directly to S_START. There is no idle gap.
- **Simultaneous push and pop:**
  - When full: both succeed, the count is unchanged and `overflow` is not set.
  - When empty: the pop is not performed (emptiness is judged before the push); the push succeeds.
- **Mode 00:** no action.
- **Reset mid-frame:** `uart_tx`=1 in the cycle after reset is sampled; the partial frame is abandoned and the FIFO contents are lost.

## Timing
- All outputs are registered.
- **Start latency:** in the start cycle (S_IDLE, `mode`==11, non-empty) the pop occurs. From the next cycle, `uart_tx`=0 and `busy`=1.
- **Frame length:** (1 + 8 + P + `STOP_BITS`) × `CLKS_PER_BIT` cycles, where P is 1 with parity and 0 without.
- `busy` falls in the cycle after the last stop cycle, unless a back-to-back frame starts.
- **Flags:** `fifo_empty`, `fifo_full` and `overflow` update in the cycle after the push/pop edge.
- **Baud counter:** width is $clog2(`CLKS_PER_BIT`). It reloads on every bit boundary and cannot drift across frames.
- **FIFO occupancy counter:** width is $clog2(`FIFO_DEPTH`)+1. Pointers wrap modulo `FIFO_DEPTH`.

## Configuration
- **`PTU_PARITY_EN` defined:** a parity bit follows data bit 7.
  - Parity bit = XOR of the 8 data bits, inverted when `PARITY_ODD`=1.
  - S_PARITY exists in the FSM.
- **Not defined:** no parity logic, no S_PARITY state; `PARITY_ODD` is ignored.

## Structure
- **Package `ptu_pkg`:**
  - mode codes: `MODE_IDLE`, `MODE_LOAD_LSB`, `MODE_LOAD_MSB`, `MODE_SEND`
  - FSM state enum: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
- **Sub-module `ptu_fifo`:** synchronous byte FIFO, parametrised by `FIFO_DEPTH`, providing push, pop, head data, empty, full and count. It is instantiated once.
- Top level contains the nibble capture, the edge detect on `mode`, and the TX FSM with its baud and bit counters.

## Test plan
- **Reset defaults:** assert `reset` for 2 cycles with `mode`=11 → all outputs at their reset values, and `uart_tx` stays 1 for 50 cycles.
- **Single frame** (`CLKS_PER_BIT`=4, no parity): LOAD_LSB with 0x5, LOAD_MSB with 0xA, then SEND → `uart_tx` 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1; `busy` high for exactly 40 cycles.
- **Parity** (with `PTU_PARITY_EN`, `PARITY_ODD`=0): send 0xA5 → parity bit 0. Send 0x07 → parity bit 1. Each frame is 44 cycles.
- **Back-to-back:** load 0x11, 0x22, 0x33 (`FIFO_DEPTH`=4), hold SEND → three contiguous frames with no high gap between stop and start; `fifo_empty` rises after the third pop.
- **Overflow:** push 5 bytes into a depth-4 FIFO while in non-SEND modes → the 5th is dropped, `overflow`=1, `fifo_full`=1, and a later SEND emits only the first 4 bytes.
- **Mid-frame events:**
  - Change `mode` to 00 during data bit 3 → the frame completes and no further frame starts.
  - Assert `reset` during data bit 3 → `uart_tx`=1 next cycle and `fifo_empty`=1.
